// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension multiply/divide unit, one result bit per clock.
// Define MDU_DIV_EN to build the restoring divider; without it, divide ops return err.
module mul_div_unit #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [D_WIDTH-1:0] bus_a,
    input  logic [D_WIDTH-1:0] bus_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out,
    output logic               Z,
    output logic               err
);

    localparam int W  = D_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0]  LAST  = CW'(W - 1);
    localparam logic [W-1:0]   ZERO  = '0;
    localparam logic [2*W-1:0] ZERO2 = '0;
`ifdef MDU_DIV_EN
    localparam logic [W-1:0]   MIN   = {1'b1, {(W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    logic [1:0]     op_q;
    logic           neg_q;
    logic [W-1:0]   opb;
    logic [2*W-1:0] work;
    logic [CW-1:0]  cnt;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [W-1:0]   out_q;
    logic           z_q;
    logic           err_q;
`ifdef MDU_DIV_EN
    logic           is_div_q;
`endif

    logic           a_sgn;
    logic           b_sgn;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           neg_in;
    logic           bypass;
    logic [W-1:0]   byp_res;
    logic           byp_err;

    // Operands are reduced to magnitudes here; the sign is reapplied to the final result.
    always_comb begin
        a_sgn  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_sgn  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg  = a_sgn && bus_a[W-1];
        b_neg  = b_sgn && bus_b[W-1];
        a_mag  = a_neg ? (ZERO - bus_a) : bus_a;
        b_mag  = b_neg ? (ZERO - bus_b) : bus_b;
        neg_in = (op == 3'b110) ? a_neg : (a_neg ^ b_neg);
    end

    always_comb begin
        bypass  = 1'b0;
        byp_res = ZERO;
        byp_err = 1'b0;
`ifdef MDU_DIV_EN
        if (op[2] && (bus_b == ZERO)) begin
            bypass  = 1'b1;
            byp_err = 1'b1;
            byp_res = op[1] ? bus_a : ~ZERO;
        end else if (op[2] && !op[0] && (bus_a == MIN) && (bus_b == ~ZERO)) begin
            bypass  = 1'b1;
            byp_res = op[1] ? ZERO : MIN;
        end
`else
        if (op[2]) begin
            bypass  = 1'b1;
            byp_err = 1'b1;
        end
`endif
    end

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [2*W-1:0] next_work;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   res;

    // Shift-add: low half holds the multiplier, high half accumulates and shifts right.
    always_comb begin
        mul_sum  = {1'b0, work[2*W-1:W]} + {1'b0, (work[0] ? opb : ZERO)};
        mul_next = {mul_sum, work[W-1:1]};
    end

`ifdef MDU_DIV_EN
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;
    logic [W-1:0]   div_val;

    // Restoring divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    always_comb begin
        div_shift = {work[2*W-1:W], work[W-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_next  = div_diff[W] ? {div_shift[W-1:0], work[W-2:0], 1'b0}
                                : {div_diff[W-1:0], work[W-2:0], 1'b1};
    end
`endif

    always_comb begin
`ifdef MDU_DIV_EN
        next_work = is_div_q ? div_next : mul_next;
`else
        next_work = mul_next;
`endif
        prod_fix = neg_q ? (ZERO2 - next_work) : next_work;
        res      = (op_q == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
`ifdef MDU_DIV_EN
        div_val  = op_q[1] ? next_work[2*W-1:W] : next_work[W-1:0];
        if (is_div_q) begin
            res = neg_q ? (ZERO - div_val) : div_val;
        end
`endif
    end

    // Control FSM; result, flags and handshakes are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= 2'b00;
            neg_q       <= 1'b0;
            opb         <= ZERO;
            work        <= ZERO2;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= ZERO;
            z_q         <= 1'b0;
            err_q       <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q       <= op[1:0];
                        neg_q      <= neg_in;
                        opb        <= b_mag;
                        work       <= {ZERO, a_mag};
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
`ifdef MDU_DIV_EN
                        is_div_q   <= op[2];
`endif
                        if (bypass) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            out_q       <= byp_res;
                            z_q         <= (byp_res == ZERO);
                            err_q       <= byp_err;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    work <= next_work;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        out_q       <= res;
                        z_q         <= (res == ZERO);
                        err_q       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_q       <= ZERO;
                        z_q         <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_q       <= ZERO;
                    z_q         <= 1'b0;
                    err_q       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign Z         = z_q;
    assign err       = err_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, operand/result width; legal values are even integers 8..64.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- op  input  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- bus_a  input  D_WIDTH  operand A (multiplicand/dividend).
- bus_b  input  D_WIDTH  operand B (multiplier/divisor).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out  output  D_WIDTH  result.
- Z  output  1  out equals zero.
- err  output  1  divide-by-zero, or division requested while compiled out.
REQ-003 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-005 Acceptance SHALL occur on an edge where in_valid and in_ready are both 1; op, bus_a, bus_b SHALL be latched then, and later input changes SHALL be ignored.
REQ-006 On acceptance, normal operations SHALL go IDLE->CALC; CALC SHALL last exactly D_WIDTH cycles (one bit per cycle: shift-add multiply, restoring divide), then ->DONE.
REQ-007 out_valid SHALL rise exactly D_WIDTH+1 edges after the acceptance edge for normal operations.
REQ-008 Divisor zero and signed overflow (bus_a = most-negative, bus_b = all-ones, DIV/REM) SHALL bypass CALC: IDLE->DONE, out_valid 1 edge after acceptance.
REQ-009 In DONE, out_valid SHALL be 1 with out, Z and err held stable until an edge with out_ready=1, which SHALL move to IDLE; no acceptance in that same cycle.
REQ-010 Signed operands SHALL be two's complement; sign handling SHALL be done on magnitudes, with the result sign corrected at the end.
REQ-011 MUL SHALL return low D_WIDTH bits of the product; MULH/MULHSU/MULHU SHALL return high D_WIDTH bits of the 2*D_WIDTH product (signed*signed, signed*unsigned, unsigned*unsigned).
REQ-012 DIV/DIVU SHALL truncate toward zero; REM/REMU SHALL take the sign of the dividend.
REQ-013 Divide by zero: quotient SHALL be all-ones, remainder SHALL equal bus_a, err=1.
REQ-014 Signed overflow: DIV SHALL return the most-negative value, REM SHALL return 0, err=0.
REQ-015 Z SHALL equal (out==0) whenever out_valid=1; out, Z and err SHALL be 0 whenever out_valid=0.

Reset
REQ-016 rst=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, out=0, Z=0, err=0, from any state including mid-CALC; a partial result SHALL be discarded and never presented.
REQ-017 rst SHALL override a simultaneous in_valid; no request SHALL be accepted on a reset edge.

Configuration
REQ-018 Macro MDU_DIV_EN SHALL gate the divider datapath.
REQ-019 With MDU_DIV_EN defined: all eight operations SHALL behave per REQ-004..REQ-015.
REQ-020 Without MDU_DIV_EN: no divider logic SHALL be synthesised; ops 100-111 SHALL go IDLE->DONE with out=0, Z=1, err=1, out_valid 1 edge after acceptance; multiply ops SHALL be unchanged.

Verification (D_WIDTH=32)
REQ-021 MUL 7 x 0xFFFFFFFD -> out_valid exactly 33 edges after acceptance, out=0xFFFFFFEB, Z=0, err=0.
REQ-022 MULH 0x80000000 x 0x80000000 -> out=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> out=0xFFFFFFFE.
REQ-023 DIV 0xFFFFFFF9 / 2 -> out=0xFFFFFFFD; REM same operands -> out=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> out=0x80000000 after 1 cycle, err=0.
REQ-024 DIVU 5 / 0 -> out=0xFFFFFFFF, err=1, 1-cycle latency; REMU 5 / 0 -> out=5, err=1.
REQ-025 out_ready held 0 for 10 cycles in DONE -> out/Z/err stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-026 rst pulsed at CALC cycle 10 -> next edge IDLE, out_valid=0; following MUL 3 x 4 -> out=12 with normal 33-edge latency.
